// File: rtl/multicycle_controller_pkg.sv
// Shared types and decode helpers for the multi-cycle CPU controller.
package cpu_ctrl_pkg;

  // Controller states; codes 6 and 7 are unused and recover to FETCH.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  // Instruction opcodes (low four bits of the opcode field).
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BLT  = 4'hA;
  localparam logic [3:0] OP_BGT  = 4'hB;
  localparam logic [3:0] OP_LD   = 4'hC;
  localparam logic [3:0] OP_ST   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_ADDI = 4'hF;

  // ALU operations the controller issues on its own (address add, compare).
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  // Register-register ALU ops: operand B from the register file.
  function automatic logic is_alu_rtype(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_OR, OP_AND};
  endfunction

  // Immediate / unary ALU ops: operand B from the immediate.
  function automatic logic is_alu_itype(input logic [3:0] op);
    return op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_NOT, OP_ADDI};
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return op inside {OP_BEQ, OP_BLT, OP_BGT};
  endfunction

  // Arithmetic ops whose signed overflow can suppress write-back.
  function automatic logic is_ovf_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_ADDI};
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the controller (master) and datapath (slave).
interface multicycle_controller_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                Zero;
  logic                Negative;
  logic                Overflow;
  logic                i_mem_ready;
  logic                d_mem_ready;
  logic                pc_load;
  logic                i_mem_oe;
  logic                ir_load;
  logic                rf_mux_sel;
  logic                rf_write_en;
  logic                alu_mux_sel;
  logic [ALU_OP_W-1:0] alu_opcode;
  logic                d_mem_rw_;
  logic                d_mem_cs;
  logic                data_out_mux;
  logic                branch;
  logic                jump;
  logic                ovf_trap;
  logic                mem_timeout_err;
  logic [CNT_W-1:0]    retire_count;
  logic [2:0]          state_o;

  modport master (
    input  opcode, Zero, Negative, Overflow, i_mem_ready, d_mem_ready,
    output pc_load, i_mem_oe, ir_load, rf_mux_sel, rf_write_en, alu_mux_sel,
           alu_opcode, d_mem_rw_, d_mem_cs, data_out_mux, branch, jump,
           ovf_trap, mem_timeout_err, retire_count, state_o
  );

  modport slave (
    output opcode, Zero, Negative, Overflow, i_mem_ready, d_mem_ready,
    input  pc_load, i_mem_oe, ir_load, rf_mux_sel, rf_write_en, alu_mux_sel,
           alu_opcode, d_mem_rw_, d_mem_cs, data_out_mux, branch, jump,
           ovf_trap, mem_timeout_err, retire_count, state_o
  );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts MEM-state cycles spent waiting on d_mem_ready; flags the last allowed one.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);
  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count;

  // Wait counter: cleared on entry to MEM, advances on each not-ready cycle.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 8'd1;
  end

  // Only meaningful while waiting; the FSM gives d_mem_ready priority.
  assign timeout = enable && (count == LAST);
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// data-memory timeout, optional overflow trap and retired-instruction counter.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int OVF_TRAP_EN = 0,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic rst,
  multicycle_controller_if.master bus
);
  state_e           state;
  logic [3:0]       op;
  logic             legal;
  logic             is_ld;
  logic             is_st;
  logic             timeout;
  logic [CNT_W-1:0] retire_count;

  logic pc_load, i_mem_oe, ir_load, rf_mux_sel, rf_write_en, alu_mux_sel;
  logic d_mem_rw_, d_mem_cs, data_out_mux, branch, jump, ovf_trap;
  logic [ALU_OP_W-1:0] alu_opcode;

  assign op    = bus.opcode[3:0];
  assign legal = (bus.opcode >> 4) == OPCODE_W'(0);
  assign is_ld = (op == OP_LD);
  assign is_st = (op == OP_ST);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_EXEC),
    .enable  ((state == S_MEM) && !bus.d_mem_ready),
    .timeout (timeout)
  );

  // State sequencing; ERROR is left only through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (bus.i_mem_ready) state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (!legal)                                state <= S_FETCH;
          else if (is_alu_rtype(op) || is_alu_itype(op)) state <= S_WB;
          else if (is_ld || is_st)                   state <= S_MEM;
          else                                       state <= S_FETCH;
        end
        S_MEM: begin
          if (bus.d_mem_ready) state <= is_ld ? S_WB : S_FETCH;
          else if (timeout)    state <= S_ERROR;
        end
        S_WB:    state <= S_FETCH;
        S_ERROR: state <= S_ERROR;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Datapath strobes from the current state and inputs; forced idle in reset.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    pc_load      = 1'b0;
    i_mem_oe     = 1'b0;
    ir_load      = 1'b0;
    rf_mux_sel   = 1'b1;
    rf_write_en  = 1'b0;
    alu_mux_sel  = 1'b0;
    alu_opcode   = '0;
    d_mem_rw_    = 1'b0;
    d_mem_cs     = 1'b0;
    data_out_mux = 1'b1;
    branch       = 1'b0;
    jump         = 1'b0;
    ovf_trap     = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          i_mem_oe = 1'b1;
          ir_load  = bus.i_mem_ready;
        end
        S_EXEC: begin
          if (!legal) begin
            pc_load = 1'b1;
          end else if (is_alu_rtype(op)) begin
            alu_opcode = ALU_OP_W'(op);
          end else if (is_alu_itype(op)) begin
            alu_opcode  = ALU_OP_W'(op);
            alu_mux_sel = 1'b1;
            rf_mux_sel  = 1'b0;
          end else if (is_branch(op)) begin
            alu_opcode   = ALU_OP_W'(ALU_SUB);
            data_out_mux = 1'b0;
            pc_load      = 1'b1;
            case (op)
              OP_BEQ:  branch = bus.Zero;
              OP_BLT:  branch = bus.Negative;
              default: branch = !bus.Zero && !bus.Negative;
            endcase
          end else if (op == OP_JMP) begin
            jump    = 1'b1;
            pc_load = 1'b1;
          end else begin
            alu_opcode  = ALU_OP_W'(ALU_ADD);
            alu_mux_sel = 1'b1;
          end
        end
        S_MEM: begin
          d_mem_cs    = 1'b1;
          alu_mux_sel = 1'b1;
          d_mem_rw_   = is_ld;
          pc_load     = bus.d_mem_ready && is_st;
        end
        S_WB: begin
          rf_write_en = 1'b1;
          pc_load     = 1'b1;
          if (is_ld) begin
            rf_mux_sel   = 1'b0;
            data_out_mux = 1'b0;
          end else begin
            alu_opcode  = ALU_OP_W'(op);
            alu_mux_sel = is_alu_itype(op);
            rf_mux_sel  = is_alu_rtype(op);
          end
          if ((OVF_TRAP_EN != 0) && bus.Overflow && is_ovf_op(op)) begin
            rf_write_en = 1'b0;
            ovf_trap    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Retired-instruction counter, one step per PC update, wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         retire_count <= '0;
    else if (pc_load) retire_count <= retire_count + CNT_W'(1);
  end

  assign bus.pc_load         = pc_load;
  assign bus.i_mem_oe        = i_mem_oe;
  assign bus.ir_load         = ir_load;
  assign bus.rf_mux_sel      = rf_mux_sel;
  assign bus.rf_write_en     = rf_write_en;
  assign bus.alu_mux_sel     = alu_mux_sel;
  assign bus.alu_opcode      = alu_opcode;
  assign bus.d_mem_rw_       = d_mem_rw_;
  assign bus.d_mem_cs        = d_mem_cs;
  assign bus.data_out_mux    = data_out_mux;
  assign bus.branch          = branch;
  assign bus.jump            = jump;
  assign bus.ovf_trap        = ovf_trap;
  assign bus.mem_timeout_err = (state == S_ERROR);
  assign bus.retire_count    = retire_count;
  assign bus.state_o         = state;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle combinational CPU controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, with ready handshakes to instruction and data memory and a data-memory timeout.
- Adds an optional overflow trap and a retired-instruction counter.
- Sits between the instruction register/flags and the 16-bit datapath: PC, RF, ALU, DMEM.

Parameters:
- OPCODE_W, 4, opcode width. Decoding uses opcode[3:0]; upper bits must be 0, otherwise the instruction is treated as illegal.
- ALU_OP_W, 4, width of alu_opcode.
- MEM_TIMEOUT, 15, maximum MEM-state cycles waiting for d_mem_ready before ERROR. Legal range 1..255.
- OVF_TRAP_EN, 0, when 1, add/sub/addi results with Overflow=1 are not written back.
- CNT_W, 16, width of retire_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  opcode field of the instruction register.
- Zero  in  1  ALU zero flag, combinational from the current ALU operands.
- Negative  in  1  ALU negative flag.
- Overflow  in  1  ALU overflow flag.
- i_mem_ready  in  1  instruction memory data valid.
- d_mem_ready  in  1  data memory access complete.
- pc_load  out  1  PC update strobe, one cycle per retired instruction.
- i_mem_oe  out  1  instruction memory output enable.
- ir_load  out  1  instruction register capture strobe.
- rf_mux_sel  out  1  RF write-data select: 1=ALU R-type, 0=imm/mem path.
- rf_write_en  out  1  RF write enable.
- alu_mux_sel  out  1  ALU B select: 0=register, 1=immediate.
- alu_opcode  out  ALU_OP_W  ALU operation.
- d_mem_rw_  out  1  1=read, 0=write.
- d_mem_cs  out  1  data memory chip select.
- data_out_mux  out  1  write-back select: 1=ALU, 0=DMEM.
- branch  out  1  take-branch.
- jump  out  1  take-jump.
- ovf_trap  out  1  one-cycle pulse when a write-back is suppressed by overflow.
- mem_timeout_err  out  1  sticky error flag.
- retire_count  out  CNT_W  retired instruction count, wraps modulo 2^CNT_W.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset (rst=0, async):
  - State goes to FETCH.
  - All outputs are 0 except rf_mux_sel=1 and data_out_mux=1.
  - retire_count=0, wait counter=0, mem_timeout_err=0.
  - Reset mid-instruction aborts it with no RF or DMEM side effect after the reset edge.
- All strobes are Moore/Mealy combinational from the registered state plus inputs. They are valid in the same cycle. Defaults are as at reset.
- FETCH:
  - i_mem_oe=1.
  - If i_mem_ready: ir_load=1, next state DECODE. Otherwise stay in FETCH, with no timeout.
- DECODE:
  - Always one cycle, then EXEC.
  - Only i_mem_oe=0; there are no datapath strobes.
- EXEC: alu_opcode and alu_mux_sel are driven per opcode.
  - 0000-0011 (add/sub/or/and): alu_opcode=opcode, alu_mux_sel=0, rf_mux_sel=1. Next state WB.
  - 0100-1000 (shl, shr, rol, ror, not) and 1111 (addi): alu_opcode=opcode, alu_mux_sel=1, rf_mux_sel=0. Next state WB.
  - 1001/1010/1011 (beq/blt/bgt): alu_opcode=0001, data_out_mux=0.
    - branch=1 if, respectively, Zero; Negative; !Zero&&!Negative.
    - pc_load=1 in either case. Next state FETCH.
  - 1110 (jmp): jump=1, pc_load=1. Next state FETCH.
  - 1100 (ld) / 1101 (st): alu_opcode=0000, alu_mux_sel=1. Next state MEM, wait counter cleared.
  - Illegal opcode (upper bits non-zero): pc_load=1 only, acting as a NOP. Next state FETCH.
- MEM:
  - d_mem_cs=1 and alu_mux_sel=1 are held for the whole state.
  - ld: d_mem_rw_=1. st: d_mem_rw_=0.
  - If d_mem_ready: ld goes to WB; st asserts pc_load=1 and goes to FETCH.
  - If not ready: the counter increments. When the counter equals MEM_TIMEOUT-1 and ready is still low, next state is ERROR.
  - If ready and timeout occur in the same cycle, ready wins.
- WB:
  - rf_write_en=1 and pc_load=1. Next state FETCH.
  - ld: rf_mux_sel=0, data_out_mux=0.
  - ALU ops: the EXEC mux settings are held, with data_out_mux=1.
  - If OVF_TRAP_EN and Overflow and opcode is add/sub/addi: rf_write_en=0 and ovf_trap=1. pc_load is still 1.
- ERROR:
  - All enables 0, mem_timeout_err=1.
  - Left only by reset.
- retire_count increments on every cycle with pc_load=1.
- Latency with ready=1 on first cycle:
  - ALU ops: 4 cycles.
  - Branch/jump: 3 cycles.
  - ld: 5 cycles.
  - st: 4 cycles.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5. Codes 6/7 are unreachable and recover to FETCH.

Decomposition:
- Package cpu_ctrl_pkg contains:
  - State enum (3-bit).
  - Opcode localparams OP_ADD..OP_ADDI.
  - ALU op localparams.
  - An is_alu_rtype/is_branch helper function.
- Sub-module mem_wait_timer contains the wait counter, with clear/enable inputs and a timeout output, parametrised by MEM_TIMEOUT.

Test Plan:
- Reset mid-MEM: rst=0 while in MEM for st → d_mem_cs=0 immediately, state_o=0, retire_count=0. After release, FETCH asserts i_mem_oe=1.
- add (0000) with both ready=1 → states 0,1,2,4. rf_write_en=1 and pc_load=1 only in cycle 4. retire_count 0→1.
- beq with Zero=1, then with Zero=0 → branch=1/pc_load=1, then branch=0/pc_load=1, both in EXEC, 3 cycles each. bgt with Negative=1 → branch=0.
- ld with d_mem_ready low for 3 cycles → d_mem_cs=1 and d_mem_rw_=1 for 4 MEM cycles, then WB with data_out_mux=0 and rf_write_en=1. Total 8 cycles.
- st with d_mem_ready stuck low, MEM_TIMEOUT=15 → ERROR entered after 15 MEM cycles, mem_timeout_err=1 sticky, no pc_load. Cleared only by rst.
- OVF_TRAP_EN=1, addi with Overflow=1 in WB → rf_write_en=0, ovf_trap=1, pc_load=1. With CNT_W=4, 16 retirements wrap retire_count to 0.
